// File: rtl/bheap_scan_sequencer.sv
// bheap_scan_sequencer: stream-side sequencer for a scan-mode binary heap array.
// It fills the heap scan chain, runs the heap controller, and then drains the chain to an output stream.
module bheap_scan_sequencer #(
  parameter int WIDTH  = 32,
  parameter int NODES  = 3,
  parameter int CWIDTH = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [CWIDTH-1:0] Count,
  output logic              Busy,
  input  logic              InValid,
  output logic              InReady,
  input  logic [WIDTH-1:0]  InData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [WIDTH-1:0]  OutData,
  output logic [WIDTH-1:0]  ScanOut,
  input  logic [WIDTH-1:0]  ScanIn,
  output logic              ScanEnable,
  output logic              HeapGo,
  output logic [CWIDTH-1:0] HeapCount,
  input  logic              HeapDone
);

  localparam int CNTW = $clog2(NODES + 1);
  localparam logic [CNTW-1:0] LAST = CNTW'(NODES - 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(NODES);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GO,
    WAIT,
    UNLOAD
  } state_t;

  state_t            state_q, state_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic              outValid_q, outValid_d;
  logic [WIDTH-1:0]  outData_q, outData_d;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      cnt_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      cnt_q      <= cnt_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
    end
  end

  // Unload only refills the output register once it is empty or is being taken this cycle,
  // so the chain never shifts while the consumer stalls.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    cnt_d      = cnt_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    ScanEnable = 1'b0;
    ScanOut    = '0;
    HeapGo     = 1'b0;
    HeapCount  = '0;

    unique case (state_q)
      IDLE: begin
        if (Start) begin
          count_d = Count;
          cnt_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (InValid) begin
          ScanEnable = 1'b1;
          ScanOut    = InData;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = (count_q != '0) ? GO : UNLOAD;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
      end
      GO: begin
        HeapGo    = 1'b1;
        HeapCount = count_q;
        state_d   = WAIT;
      end
      WAIT: begin
        if (HeapDone) begin
          cnt_d   = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (!outValid_q || OutReady) begin
          if (cnt_q != FULL) begin
            ScanEnable = 1'b1;
            outData_d  = ScanIn;
            outValid_d = 1'b1;
            cnt_d      = cnt_q + CNTW'(1);
          end else begin
            outValid_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy     = (state_q != IDLE);
  assign InReady  = (state_q == LOAD);
  assign OutValid = outValid_q;
  assign OutData  = outData_q;

endmodule

// File: tb/tb_bheap_scan_sequencer.sv
// Self-checking bench for bheap_scan_sequencer. It emulates the scan chain and a max-heap controller,
// and a per-cycle compare process checks the DUT against a job-level model.
module tb_bheap_scan_sequencer;

  localparam int WIDTH  = 32;
  localparam int NODES  = 3;
  localparam int CWIDTH = 8;

  typedef logic [NODES-1:0][WIDTH-1:0] heap_t;

  logic              Clk, Reset, Start, InValid, OutReady;
  logic [CWIDTH-1:0] Count;
  logic [WIDTH-1:0]  InData;
  logic              Busy, InReady, OutValid, ScanEnable, HeapGo, HeapDone;
  logic [WIDTH-1:0]  OutData, ScanOut, ScanIn;
  logic [CWIDTH-1:0] HeapCount;

  bit heapDoneEmu = 1'b0;
  bit heapDoneForce;
  assign HeapDone = heapDoneEmu | heapDoneForce;

  bheap_scan_sequencer #(.WIDTH(WIDTH), .NODES(NODES), .CWIDTH(CWIDTH)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Count(Count), .Busy(Busy),
    .InValid(InValid), .InReady(InReady), .InData(InData),
    .OutValid(OutValid), .OutReady(OutReady), .OutData(OutData),
    .ScanOut(ScanOut), .ScanIn(ScanIn), .ScanEnable(ScanEnable),
    .HeapGo(HeapGo), .HeapCount(HeapCount), .HeapDone(HeapDone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Max-heap: each iteration sifts the root down; heap index k is the k-th loaded word.
  function automatic heap_t heapRun(heap_t h, int iters);
    int k, l, r, big;
    bit done;
    logic [WIDTH-1:0] t;
    for (int it = 0; it < iters; it++) begin
      k = 0;
      done = 1'b0;
      while (!done) begin
        l = 2 * k + 1;
        r = 2 * k + 2;
        big = k;
        if (l < NODES && h[l] > h[big]) big = l;
        if (r < NODES && h[r] > h[big]) big = r;
        if (big == k) done = 1'b1;
        else begin
          t = h[k]; h[k] = h[big]; h[big] = t; k = big;
        end
      end
    end
    return h;
  endfunction

  function automatic heap_t mk(logic [WIDTH-1:0] a, logic [WIDTH-1:0] b, logic [WIDTH-1:0] c);
    heap_t h;
    h[0] = a; h[1] = b; h[2] = c;
    return h;
  endfunction

  // Scan chain plus heap controller; chain[NODES-1] is the tail, which holds the root.
  logic [WIDTH-1:0] chain [NODES];
  int heapTimer = 0;
  int pendIters = 0;
  heap_t emuH;
  assign ScanIn = chain[NODES-1];

  always @(posedge Clk) begin
    heapDoneEmu <= 1'b0;
    if (ScanEnable) begin
      for (int i = NODES - 1; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= ScanOut;
    end
    if (HeapGo) begin
      pendIters <= int'(HeapCount);
      heapTimer <= 4;
    end else if (heapTimer > 1) begin
      heapTimer <= heapTimer - 1;
    end else if (heapTimer == 1) begin
      heapTimer <= 0;
      heapDoneEmu <= 1'b1;
      for (int k = 0; k < NODES; k++) emuH[k] = chain[NODES-1-k];
      emuH = heapRun(emuH, pendIters);
      for (int k = 0; k < NODES; k++) chain[NODES-1-k] <= emuH[k];
    end
  end

  // Job-level model: expected busy window, word counts and the expected output queue.
  bit               expBusy = 1'b0;
  int               loads = 0, outs = 0, heapGos = 0, scanCount = 0;
  logic [CWIDTH-1:0] jobCount = '0;
  logic [CWIDTH-1:0] lastHeapCount = '0;
  logic [WIDTH-1:0] expQ [$];
  bit               prevStall = 1'b0, expectValidNext = 1'b0;
  logic [WIDTH-1:0] prevData = '0;

  always @(negedge Clk) begin
    if (Reset) begin
      expBusy = 1'b0; loads = 0; outs = 0; heapGos = 0; scanCount = 0;
      prevStall = 1'b0; expectValidNext = 1'b0;
    end else begin
      checkOutput("busy", Busy, expBusy);
      if (!expBusy) begin
        checkOutput("idle_scan_enable", ScanEnable, 0);
        checkOutput("idle_heap_go", HeapGo, 0);
        checkOutput("idle_in_ready", InReady, 0);
        checkOutput("idle_out_valid", OutValid, 0);
      end
      if (ScanEnable) scanCount++;
      if (HeapGo) begin
        checkOutput("heap_count", HeapCount, jobCount);
        checkOutput("heap_go_after_load", loads, NODES);
        checkOutput("heap_go_no_scan", ScanEnable, 0);
        lastHeapCount = HeapCount;
        heapGos++;
      end
      if (InReady) begin
        checkOutput("load_scan_enable", ScanEnable, InValid);
        checkOutput("load_within_nodes", loads < NODES, 1);
        if (InValid) checkOutput("load_scan_out", ScanOut, InData);
      end
      if (OutValid) begin
        checkOutput("out_after_load", loads, NODES);
        checkOutput("out_after_heap", heapGos, (jobCount != 0) ? 1 : 0);
      end
      if (prevStall) begin
        checkOutput("stall_valid_held", OutValid, 1);
        checkOutput("stall_data_held", OutData, prevData);
      end
      if (expectValidNext) checkOutput("unload_throughput", OutValid, 1);
      expectValidNext = 1'b0;
      if (OutValid && !OutReady) checkOutput("stall_no_scan", ScanEnable, 0);
      if (OutValid && OutReady) begin
        if (expQ.size() == 0) checkOutput("unexpected_out_word", OutData, 32'hFFFF_FFFF);
        else checkOutput("out_data", OutData, expQ.pop_front());
        outs++;
        if (outs == NODES) expBusy = 1'b0;
        else expectValidNext = 1'b1;
      end
      if (InValid && InReady) loads++;
      if (Start && !expBusy) begin
        expBusy = 1'b1; jobCount = Count;
        loads = 0; outs = 0; heapGos = 0; scanCount = 0;
      end
      prevStall = OutValid && !OutReady;
      prevData  = OutData;
    end
  end

  task automatic startJob(input logic [CWIDTH-1:0] cnt);
    Start = 1'b1;
    Count = cnt;
    @(posedge Clk); #1;
    Start = 1'b0;
  endtask

  task automatic loadWord(input logic [WIDTH-1:0] d, input int gap);
    bit ok;
    ok = 1'b0;
    InValid = 1'b0;
    repeat (gap) begin @(posedge Clk); #1; end
    InValid = 1'b1;
    InData  = d;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge Clk);
      if (InReady) ok = 1'b1;
      @(posedge Clk); #1;
    end
    if (!ok) checkOutput("load_timeout", 0, 1);
    InValid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [CWIDTH-1:0] cnt, input heap_t words, input heap_t expOut,
                               input int gap);
    for (int k = 0; k < NODES; k++) expQ.push_back(expOut[k]);
    startJob(cnt);
    for (int k = 0; k < NODES; k++) loadWord(words[k], gap);
  endtask

  task automatic waitOuts(input int n);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(posedge Clk); #1;
      if (outs >= n) ok = 1'b1;
    end
    if (!ok) checkOutput("out_wait_timeout", 0, 1);
  endtask

  task automatic waitJobEnd(input int expHeapGos);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(posedge Clk); #1;
      if (!Busy && outs == NODES) ok = 1'b1;
    end
    if (!ok) checkOutput("job_timeout", 0, 1);
    checkOutput("job_out_words", outs, NODES);
    checkOutput("job_heap_go_pulses", heapGos, expHeapGos);
    checkOutput("job_scan_pulses", scanCount, 2 * NODES);
    checkOutput("job_queue_drained", expQ.size(), 0);
    for (int i = 0; i < NODES; i++) checkOutput("chain_zero_filled", chain[i], 0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Count = '0; InValid = 1'b0; InData = '0;
    OutReady = 1'b1; heapDoneForce = 1'b0;
    #1;
    checkOutput("reset_busy", Busy, 0);
    checkOutput("reset_out_data", OutData, 0);
    checkOutput("reset_heap_count", HeapCount, 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    @(posedge Clk); #1;

    // 1: asynchronous reset in the middle of a load, with a word presented
    startJob(8'd2);
    loadWord(32'd11, 0);
    InValid = 1'b1; InData = 32'd77;
    #2 Reset = 1'b1;
    #1;
    checkOutput("async_rst_busy", Busy, 0);
    checkOutput("async_rst_in_ready", InReady, 0);
    checkOutput("async_rst_scan_enable", ScanEnable, 0);
    checkOutput("async_rst_scan_out", ScanOut, 0);
    checkOutput("async_rst_out_valid", OutValid, 0);
    checkOutput("async_rst_heap_go", HeapGo, 0);
    InValid = 1'b0;
    @(posedge Clk); #1 Reset = 1'b0;
    @(posedge Clk); #1;
    checkOutput("post_rst_idle", Busy, 0);

    // 2: one heap iteration on 5,9,2 gives 9,5,2
    applyStimulus(8'd1, mk(5, 9, 2), mk(9, 5, 2), 0);
    waitJobEnd(1);
    checkOutput("t2_heap_count_literal", lastHeapCount, 1);

    // 3: a zero count goes straight to unload
    applyStimulus(8'd0, mk(7, 3, 1), mk(7, 3, 1), 0);
    checkOutput("t3_not_valid_yet", OutValid, 0);
    @(posedge Clk); #1;
    checkOutput("t3_first_valid", OutValid, 1);
    checkOutput("t3_first_word", OutData, 7);
    waitJobEnd(0);

    // 4: gaps in InValid during load
    applyStimulus(8'd2, mk(4, 8, 6), heapRun(mk(4, 8, 6), 2), 1);
    waitJobEnd(1);

    // 5: a four-cycle consumer stall after the first output word
    applyStimulus(8'd1, mk(10, 20, 30), heapRun(mk(10, 20, 30), 1), 0);
    waitOuts(1);
    OutReady = 1'b0;
    repeat (4) begin @(posedge Clk); #1; end
    checkOutput("t5_stalled_valid", OutValid, 1);
    checkOutput("t5_stalled_word", OutData, 20);
    OutReady = 1'b1;
    waitJobEnd(1);

    // 6: Start during WAIT and UNLOAD is ignored; HeapDone while idle does nothing
    applyStimulus(8'd3, mk(1, 2, 3), heapRun(mk(1, 2, 3), 3), 0);
    for (int t = 0; t < 50 && heapGos == 0; t++) begin @(posedge Clk); #1; end
    checkOutput("t6_heap_started", heapGos, 1);
    startJob(8'd0);
    waitOuts(1);
    OutReady = 1'b0;
    startJob(8'd5);
    OutReady = 1'b1;
    waitJobEnd(1);
    heapDoneForce = 1'b1;
    @(posedge Clk); #1;
    heapDoneForce = 1'b0;
    repeat (3) begin @(posedge Clk); #1; end
    checkOutput("t6_idle_after_heapdone", Busy, 0);
    checkOutput("t6_no_output_idle", OutValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
